pipe_stage_elastic: RTL
=======================

PIPE_STAGE_ELASTIC -- requirements
Module: pipe_stage_elastic

Interface
REQ-001 The module SHALL expose these parameters (name, default, meaning):
- WIDTH, 64: payload width in bits.
- NOP_VALUE, {WIDTH{1'b0}}: value driven on out_data whenever the stage is empty or flushed.
- SKID, 1: 1 selects a two-entry stage (main plus skid) with registered in_ready; 0 selects a one-entry stage with combinational in_ready.
- CNT_W, 16: width of the stall counter.
REQ-002 The module SHALL expose these ports (name, direction, width, meaning):
- Clk, input, 1: single clock; all state updates on the rising edge.
- R, input, 1: reset, asynchronous, active-low.
- flush, input, 1: synchronous discard of all held entries.
- in_valid, input, 1: upstream offers in_data.
- in_ready, output, 1: stage accepts in_data this cycle.
- in_data, input, WIDTH: upstream payload.
- out_valid, output, 1: out_data holds a valid entry.
- out_ready, input, 1: downstream consumes out_data this cycle.
- out_data, output, WIDTH: oldest held entry, or NOP_VALUE.
- occupancy, output, 2: number of held entries (0, 1 or 2).
- stall_cnt, output, CNT_W: saturating count of back-pressured cycles.

Function
REQ-003 An input transfer SHALL occur on a rising edge where in_valid=1 and in_ready=1.
REQ-004 An output transfer SHALL occur on a rising edge where out_valid=1 and out_ready=1.
REQ-005 The state machine SHALL have three states: EMPTY (occupancy 0), FULL (occupancy 1), SKID_FULL (occupancy 2; reachable only when SKID=1).
REQ-006 Transitions from EMPTY:
- Input transfer: go to FULL; main <= in_data.
- Otherwise: stay in EMPTY.
REQ-007 Transitions from FULL:
- Input and output transfer together: stay in FULL; main <= in_data.
- Input transfer only: go to SKID_FULL; skid <= in_data.
- Output transfer only: go to EMPTY.
- Neither: hold state and contents.
REQ-008 Transitions from SKID_FULL:
- Output transfer: go to FULL; main <= skid.
- Otherwise: hold state and contents.
REQ-009 When SKID=1, in_ready SHALL be a registered signal equal to (state != SKID_FULL), gated low by flush.
REQ-010 When SKID=0, in_ready SHALL equal (state==EMPTY || out_ready) && !flush, so the one-entry stage passes data through under concurrent consume.
REQ-011 out_valid SHALL be 1 exactly when occupancy is nonzero.
REQ-012 out_data SHALL be the main register when out_valid=1 and NOP_VALUE otherwise.
REQ-013 Ordering SHALL be strict FIFO; no entry is ever duplicated or dropped outside flush.
REQ-014 Latency: an entry accepted into EMPTY SHALL appear on out_data in the following cycle; throughput SHALL be one transfer per cycle when out_ready is held at 1.
REQ-015 flush=1 SHALL take priority over every other event:
- Next state is EMPTY, occupancy 0 and out_data NOP_VALUE.
- in_ready is 0 during the flush cycle, so no input transfer occurs.
- Any output transfer in the same cycle still counts as consumed.
REQ-016 stall_cnt SHALL increment on each rising edge where out_valid=1 and out_ready=0.
REQ-017 stall_cnt SHALL saturate at all-ones and SHALL NOT be cleared by flush.
REQ-018 occupancy SHALL be registered and SHALL match the state encoding at all times.

Reset
REQ-019 Assertion of R=0 SHALL immediately, without waiting for a clock edge, drive all outputs to their reset values:
- State EMPTY; occupancy 0; out_valid 0; out_data NOP_VALUE; stall_cnt 0.
- in_ready 0 (SKID=1) or 0 (SKID=0, forced while R=0).
REQ-020 Reset asserted mid-operation SHALL discard both held entries.
REQ-021 After R rises, the first input transfer SHALL be possible on the first rising edge following deassertion, with in_ready=1.

Verification
REQ-022 SKID=1 back-pressure sequence:
- Offer 0xA, 0xB, 0xC on consecutive cycles with out_ready=0.
- 0xA and 0xB are accepted; in_ready falls after the second accept; occupancy=2; stall_cnt counts up.
- Raising out_ready drains 0xA then 0xB, and 0xC is accepted once in_ready returns.
REQ-023 Streaming: with in_valid and out_ready held at 1 for 100 cycles, the stage delivers 100 words in order, one per cycle, at 1-cycle latency, with stall_cnt=0.
REQ-024 Flush:
- Stage in SKID_FULL holding 0x11 and 0x22; assert flush with in_valid=1 and in_data=0x33.
- Next cycle: occupancy=0, out_data=NOP_VALUE, and 0x33 is never output.
REQ-025 Asynchronous reset: drop R between clock edges while FULL; out_valid=0 and stall_cnt=0 before the next edge.
REQ-026 SKID=0 pass-through: FULL holding 0x5 with out_ready=1 and in_valid=1 carrying 0x6; in_ready=1, 0x5 is consumed, 0x6 is held, and occupancy stays 1.
REQ-027 Saturation (CNT_W=4): hold out_valid=1 and out_ready=0 for 20 cycles; stall_cnt stops at 15.

Source files
------------

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline stage with valid/ready handshakes on both sides.
// SKID=1 builds a two-entry stage (main + skid) whose in_ready comes from a
// flop, which breaks the combinational ready path from downstream.
// SKID=0 builds a one-entry stage whose in_ready looks at out_ready, so that
// data can pass through when the held word is consumed in the same cycle.
// out_data always shows the oldest held entry, or NOP_VALUE when the stage is empty.
module pipe_stage_elastic #(
  parameter int unsigned      WIDTH     = 64,
  parameter logic [WIDTH-1:0] NOP_VALUE = {WIDTH{1'b0}},
  parameter bit               SKID      = 1'b1,
  parameter int unsigned      CNT_W     = 16
) (
  input  logic             Clk,
  input  logic             R,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY     = 2'd0,
    ST_FULL      = 2'd1,
    ST_SKID_FULL = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Control state
  state_e           state_q, state_d;
  logic [1:0]       occupancy_q, occupancy_d;
  logic             out_valid_q, out_valid_d;
  logic             rdy_q, rdy_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Payload registers; these are never reset because out_data is masked by out_valid
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;

  logic in_xfer;
  logic out_xfer;

  // Upstream ready: taken from a flop in skid mode, or looks through to out_ready in one-entry mode
  always_comb begin
    in_ready = 1'b0;
    if (SKID) begin
      in_ready = rdy_q & R & ~flush;
    end else begin
      in_ready = R & ((state_q == ST_EMPTY) | out_ready) & ~flush;
    end
  end

  // Handshake qualifiers and the visible outputs
  always_comb begin
    in_xfer   = in_valid & in_ready;
    out_xfer  = out_valid_q & out_ready;
    out_valid = out_valid_q;
    occupancy = occupancy_q;
    stall_cnt = stall_cnt_q;
    out_data  = out_valid_q ? main_q : NOP_VALUE;
  end

  // Next state and payload movement; flush overrides every handshake
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (in_xfer) begin
            state_d = ST_FULL;
            main_d  = in_data;
          end
        end
        ST_FULL: begin
          if (in_xfer && out_xfer) begin
            main_d = in_data;
          end else if (in_xfer) begin
            // Only reachable with SKID=1: one-entry ready needs out_ready while full
            state_d = ST_SKID_FULL;
            skid_d  = in_data;
          end else if (out_xfer) begin
            state_d = ST_EMPTY;
          end
        end
        ST_SKID_FULL: begin
          if (out_xfer) begin
            state_d = ST_FULL;
            main_d  = skid_q;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end
  end

  // Registered views derived from the next state so they always agree with it
  always_comb begin
    occupancy_d = 2'd0;
    unique case (state_d)
      ST_EMPTY:     occupancy_d = 2'd0;
      ST_FULL:      occupancy_d = 2'd1;
      ST_SKID_FULL: occupancy_d = 2'd2;
      default:      occupancy_d = 2'd0;
    endcase
    out_valid_d = (state_d != ST_EMPTY);
    rdy_d       = (state_d != ST_SKID_FULL);
  end

  // Stall counter: counts cycles where a valid word waits on downstream; sticks at all-ones
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid_q && !out_ready && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end
  end

  // Control flops with asynchronous active-low reset
  always_ff @(posedge Clk or negedge R) begin
    if (!R) begin
      state_q     <= ST_EMPTY;
      occupancy_q <= 2'd0;
      out_valid_q <= 1'b0;
      rdy_q       <= 1'b1;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      occupancy_q <= occupancy_d;
      out_valid_q <= out_valid_d;
      rdy_q       <= rdy_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Payload flops, no reset
  always_ff @(posedge Clk) begin
    main_q <= main_d;
    skid_q <= skid_d;
  end

endmodule
